// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter slice.
//   state_t       : arbiter FSM encoding
//   REQ_C / REQ_L : requester ids (CPU MEM stage / UART loader)
//   *_DEF         : default BRAM geometry
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;

    localparam logic REQ_C = 1'b0;
    localparam logic REQ_L = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_grant_picker.sv
// -----------------------------------------------------------------------------
// dmem_grant_picker
// Two-way grant selection between the CPU (bit 0) and loader (bit 1).
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : on simultaneous requests the port named by pointer wins
//   undefined : the CPU always wins on simultaneous requests
// Ports
//   reqs    in  2  request vector {loader, cpu}
//   pointer in  1  round-robin favoured requester id
//   grant   out 1  granted requester id (REQ_C / REQ_L)
// -----------------------------------------------------------------------------
module dmem_grant_picker
    import dmem_arb_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       pointer,
    output logic       grant
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        grant = REQ_C;
        if (reqs == 2'b11) begin
            grant = pointer;
        end else if (reqs[1]) begin
            grant = REQ_L;
        end
    end
`else
    // Pointer only matters for round-robin builds.
    logic unused_pointer;
    assign unused_pointer = pointer;

    always_comb begin
        grant = REQ_C;
        if (!reqs[0] && reqs[1]) begin
            grant = REQ_L;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Sole master of the single-port data BRAM. Shares it between the CPU MEM
// stage (port C) and the UART loader (port L), sequencing each access through
// the BRAM read latency and returning a one-cycle ack per transaction.
// Configuration macro: DMEM_ARB_RR_EN (round-robin grant, see grant picker).
// Parameters
//   ADDR_W  BRAM word-address width
//   DATA_W  data width
//   RD_LAT  BRAM read latency in cycles (1..2)
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata   CPU request (byte address), held until c_ack
//   c_ack/c_rdata/c_stall       CPU completion pulse, read data, pipeline stall
//   l_req/l_we/l_addr/l_wdata   loader request, same protocol
//   l_ack/l_rdata               loader completion pulse, read data
//   mem_addr/mem_din/mem_wea    BRAM addra/dina/wea
//   mem_dout                    BRAM douta
//
// state  | meaning
// IDLE   | sample requests, latch winner's fields, drive mem_* for next cycle
// ACCESS | BRAM sees address; wea high this cycle only for in-range writes
// WAIT   | extra read latency cycles (RD_LAT-1 of them)
// DONE   | ack to granted port; read data is mem_dout this cycle
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [31:0]       c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wea,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = 2;

    state_t            state;
    logic              gnt;
    logic              pointer;
    logic              we_q;
    logic              oor_q;
    logic              wea_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] l_rdata_q;

    logic              grant;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;
    logic [1:0]        unused_byte_bits;
    logic [DATA_W-1:0] rd_val;
    logic              rd_done;

    dmem_grant_picker u_picker (
        .reqs    ({l_req, c_req}),
        .pointer (pointer),
        .grant   (grant)
    );

    always_comb begin
        sel_we    = c_we;
        sel_addr  = c_addr;
        sel_wdata = c_wdata;
        if (grant == REQ_L) begin
            sel_we    = l_we;
            sel_addr  = l_addr;
            sel_wdata = l_wdata;
        end
    end

    // No byte lanes: the low address bits are dropped.
    assign unused_byte_bits = sel_addr[1:0];
    assign sel_oor          = (sel_addr[31:ADDR_W+2] != '0);

    assign rd_val  = oor_q ? '0 : mem_dout;
    assign rd_done = (state == DONE) && !we_q;

    assign c_ack   = (state == DONE) && (gnt == REQ_C);
    assign l_ack   = (state == DONE) && (gnt == REQ_L);
    assign c_stall = c_req & ~c_ack;

    // During the ack cycle the fresh BRAM word is forwarded so the data is
    // valid alongside the ack; the hold register takes it on the same edge
    // that ends the ack and keeps it until the next read ack of that port.
    assign c_rdata = (rd_done && gnt == REQ_C) ? rd_val : c_rdata_q;
    assign l_rdata = (rd_done && gnt == REQ_L) ? rd_val : l_rdata_q;

    assign mem_addr = addr_q;
    assign mem_din  = din_q;
    // The BRAM samples wea on the same edge that applies reset, so the
    // registered strobe is masked by rst to actually suppress that write.
    assign mem_wea  = wea_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= REQ_C;
            pointer   <= REQ_C;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            wea_q     <= 1'b0;
            wait_cnt  <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c_req || l_req) begin
                        gnt     <= grant;
                        pointer <= ~grant;
                        we_q    <= sel_we;
                        oor_q   <= sel_oor;
                        wea_q   <= sel_we & ~sel_oor;
                        addr_q  <= sel_addr[ADDR_W+1:2];
                        din_q   <= sel_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    wea_q <= 1'b0;
                    if (we_q || RD_LAT < 2) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= CNT_W'(RD_LAT - 2);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (!we_q) begin
                        if (gnt == REQ_C) begin
                            c_rdata_q <= rd_val;
                        end else begin
                            l_rdata_q <= rd_val;
                        end
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic        c_ack, c_stall, l_ack, mem_wea;
    logic [31:0] c_rdata, l_rdata, mem_din, mem_dout;
    logic [13:0] mem_addr;

    logic        c2_req, c2_we, l2_req, l2_we;
    logic [31:0] c2_addr, c2_wdata, l2_addr, l2_wdata;
    logic        c2_ack, c2_stall, l2_ack, m2_wea;
    logic [31:0] c2_rdata, l2_rdata, m2_din, m2_dout;
    logic [13:0] m2_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea), .mem_dout(mem_dout)
    );

    dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .c_req(c2_req), .c_we(c2_we), .c_addr(c2_addr), .c_wdata(c2_wdata),
        .c_ack(c2_ack), .c_rdata(c2_rdata), .c_stall(c2_stall),
        .l_req(l2_req), .l_we(l2_we), .l_addr(l2_addr), .l_wdata(l2_wdata),
        .l_ack(l2_ack), .l_rdata(l2_rdata),
        .mem_addr(m2_addr), .mem_din(m2_din), .mem_wea(m2_wea), .mem_dout(m2_dout)
    );

    // BRAM models: read-first, latency 1 and 2.
    logic [31:0] mem1 [0:16383];
    logic [31:0] mem2 [0:16383];
    logic [31:0] p1, p2a, p2b;

    always @(posedge clk) begin
        if (mem_wea) mem1[mem_addr] <= mem_din;
        p1 <= mem1[mem_addr];
    end
    assign mem_dout = p1;

    always @(posedge clk) begin
        if (m2_wea) mem2[m2_addr] <= m2_din;
        p2a <= mem2[m2_addr];
        p2b <= p2a;
    end
    assign m2_dout = p2b;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // One transaction from a negedge with the FSM idle; returns at a negedge
    // with the FSM idle again.
    task automatic txn(input bit d2, input bit pl, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_wea);
        int          lat;
        int          exp_lat;
        bit          stall_ok;
        logic        ack, stall;
        logic [31:0] own_prev, oth_prev, own_rd, oth_rd;
        exp_lat  = we ? 2 : (d2 ? 3 : 2);
        own_prev = d2 ? c2_rdata : (pl ? l_rdata : c_rdata);
        oth_prev = d2 ? l2_rdata : (pl ? c_rdata : l_rdata);
        if (d2) begin
            c2_we = we; c2_addr = addr; c2_wdata = wdata; c2_req = 1'b1;
        end else if (pl) begin
            l_we = we; l_addr = addr; l_wdata = wdata; l_req = 1'b1;
        end else begin
            c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
        end
        lat = 0;
        stall_ok = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            ack   = d2 ? c2_ack : (pl ? l_ack : c_ack);
            stall = d2 ? c2_stall : c_stall;
            if (k == 1) begin
                chk("mem_wea_access", 32'(d2 ? m2_wea : mem_wea), 32'(exp_wea));
                chk("mem_addr_access", 32'(d2 ? m2_addr : mem_addr), 32'(addr[15:2]));
                if (exp_wea) chk("mem_din_access", d2 ? m2_din : mem_din, wdata);
            end
            if (!pl && (stall !== ~ack)) stall_ok = 1'b0;
            if (pl && (stall !== 1'b0)) stall_ok = 1'b0;
            if (ack === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("ack_latency", lat, exp_lat);
        chk("c_stall_profile", 32'(stall_ok), 32'd1);
        own_rd = d2 ? c2_rdata : (pl ? l_rdata : c_rdata);
        oth_rd = d2 ? l2_rdata : (pl ? c_rdata : l_rdata);
        if (we) chk("rdata_held_own", own_rd, own_prev);
        else    chk("rdata", own_rd, exp_rd);
        chk("rdata_held_other", oth_rd, oth_prev);
        if (d2) c2_req = 1'b0; else if (pl) l_req = 1'b0; else c_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ack_single_pulse", 32'(d2 ? c2_ack : (pl ? l_ack : c_ack)), 32'd0);
        if (!we) chk("rdata_held_after", d2 ? c2_rdata : (pl ? l_rdata : c_rdata), exp_rd);
    endtask

    typedef struct {
        bit          pl;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_wea;
    } vec_t;

    vec_t vecs [11];

    initial begin
        bit          no_ack;
        int          n, cn, ln;
        logic [3:0]  order;
        logic [3:0]  exp_order;

        for (int i = 0; i < 16384; i++) begin
            mem1[i] = 32'hC0DE_0000 | i;
            mem2[i] = 32'hC0DE_0000 | i;
        end

        vecs[0]  = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1};
        vecs[1]  = '{0, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0};
        vecs[2]  = '{1, 1, 32'h0000_0014, 32'h1234_5678, 32'h0, 1};
        vecs[3]  = '{1, 0, 32'h0000_0014, 32'h0, 32'h1234_5678, 0};
        vecs[4]  = '{0, 0, 32'h0000_0014, 32'h0, 32'h1234_5678, 0};
        vecs[5]  = '{0, 1, 32'hFFFF_0000, 32'h0000_0001, 32'h0, 0};
        vecs[6]  = '{0, 0, 32'hFFFF_0000, 32'h0, 32'h0, 0};
        vecs[7]  = '{0, 0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 0};
        vecs[8]  = '{1, 1, 32'h0000_FFFC, 32'hA5A5_A5A5, 32'h0, 1};
        vecs[9]  = '{0, 0, 32'h0000_FFFC, 32'h0, 32'hA5A5_A5A5, 0};
        vecs[10] = '{1, 0, 32'h0001_0000, 32'h0, 32'h0, 0};

        rst = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
        c2_req = 0; c2_we = 0; c2_addr = 0; c2_wdata = 0;
        l2_req = 0; l2_we = 0; l2_addr = 0; l2_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_c_ack", 32'(c_ack), 0);
        chk("reset_l_ack", 32'(l_ack), 0);
        chk("reset_c_rdata", c_rdata, 0);
        chk("reset_l_rdata", l_rdata, 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);
        chk("reset_mem_din", mem_din, 0);
        chk("reset_mem_wea", 32'(mem_wea), 0);
        chk("reset_c_stall", 32'(c_stall), 0);

        for (int i = 0; i < 11; i++) begin
            txn(0, vecs[i].pl, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_wea);
        end

        // RD_LAT=2 instance: write then read one cycle later than RD_LAT=1.
        txn(1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1);
        txn(1, 0, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);

        // Reset while a write sits in ACCESS.
        txn(0, 0, 1, 32'h0000_0020, 32'h1111_1111, 32'h0, 1);
        c_we = 1; c_addr = 32'h0000_0020; c_wdata = 32'h2222_2222; c_req = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_wea_before", 32'(mem_wea), 1);
        rst = 1'b1;
        c_req = 1'b0;
        #1;
        chk("rstmid_wea_masked", 32'(mem_wea), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_c_ack", 32'(c_ack), 0);
        chk("rstmid_mem_wea", 32'(mem_wea), 0);
        chk("rstmid_c_rdata", c_rdata, 0);
        chk("rstmid_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;
        no_ack = 1'b1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (c_ack || l_ack) no_ack = 1'b0;
        end
        chk("rstmid_no_ack", 32'(no_ack), 1);
        txn(0, 0, 0, 32'h0000_0020, 32'h0, 32'h1111_1111, 0);

        // Contention from a fresh reset: two writes per port, both held.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c_we = 1; c_addr = 32'h40; c_wdata = 32'hC000_0000; c_req = 1;
        l_we = 1; l_addr = 32'h80; l_wdata = 32'hD000_0000; l_req = 1;
        n = 0; cn = 0; ln = 0; order = 4'hF;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (c_ack) begin
                order[n] = 1'b0; n++; cn++;
                if (cn == 2) c_req = 0; else c_addr = 32'h44;
            end
            if (l_ack) begin
                order[n] = 1'b1; n++; ln++;
                if (ln == 2) l_req = 0; else l_addr = 32'h84;
            end
        end
        c_req = 0;
        l_req = 0;
`ifdef DMEM_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b1100;
`endif
        chk("grant_order", 32'(order), 32'(exp_order));
        @(posedge clk);
        @(negedge clk);

        // Loader burst and readback with the CPU idle.
        for (int i = 0; i < 16; i++) begin
            txn(0, 1, 1, 32'(i * 4), 32'h0000_1000 + i, 32'h0, 1);
        end
        for (int i = 0; i < 16; i++) begin
            txn(0, 1, 0, 32'(i * 4), 32'h0, 32'h0000_1000 + i, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
